// File: rtl/multi_cdb_dispatch_queue.sv
// Instruction queue plus dispatcher: buffers fetched instructions, resolves
// operands against regfile, ROB and several CDB channels, issues one per cycle.
module multi_cdb_dispatch_queue #(
  parameter int IQ_DEPTH = 8,
  parameter int CDB_CH   = 2,
  parameter int ROB_W    = 4,
  parameter int XLEN     = 32,
  parameter int TYPE_W   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [XLEN-1:0]          if_ins,
  input  logic [XLEN-1:0]          if_pc,
  input  logic [XLEN-1:0]          if_pred_pc,
  input  logic                     if_pred_jump,
  output logic [XLEN-1:0]          dec_code,
  output logic [XLEN-1:0]          dec_pc,
  input  logic [TYPE_W-1:0]        dec_type,
  input  logic [4:0]               dec_rd,
  input  logic [4:0]               dec_rs1,
  input  logic [4:0]               dec_rs2,
  input  logic [XLEN-1:0]          dec_imm,
  input  logic                     dec_is_mem,
  output logic [4:0]               reg_rs1,
  output logic [4:0]               reg_rs2,
  input  logic [XLEN-1:0]          reg_Vj,
  input  logic [XLEN-1:0]          reg_Vk,
  input  logic [ROB_W-1:0]         reg_Qj,
  input  logic [ROB_W-1:0]         reg_Qk,
  output logic [ROB_W-1:0]         rob_Qj,
  output logic [ROB_W-1:0]         rob_Qk,
  input  logic [XLEN-1:0]          rob_Vj,
  input  logic [XLEN-1:0]          rob_Vk,
  input  logic                     rob_Qj_ready,
  input  logic                     rob_Qk_ready,
  input  logic [ROB_W-1:0]         rob_free_id,
  input  logic                     rob_ready,
  input  logic                     rs_ready,
  input  logic                     lsb_ready,
  input  logic [CDB_CH-1:0]        cdb_valid,
  input  logic [CDB_CH*ROB_W-1:0]  cdb_rob_id,
  input  logic [CDB_CH*XLEN-1:0]   cdb_value,
  output logic                     rename_en,
  output logic [4:0]               rename_rd,
  output logic [ROB_W-1:0]         rename_id,
  output logic                     rob_en,
  output logic                     rs_en,
  output logic                     lsb_en,
  output logic [XLEN-1:0]          out_Vj,
  output logic [XLEN-1:0]          out_Vk,
  output logic [ROB_W-1:0]         out_Qj,
  output logic [ROB_W-1:0]         out_Qk,
  output logic [TYPE_W-1:0]        out_type,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [XLEN-1:0]          out_imm,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_pred_pc,
  output logic                     out_pred_jump
);
  localparam int AW = $clog2(IQ_DEPTH);

  logic [XLEN-1:0] r_ins [IQ_DEPTH];
  logic [XLEN-1:0] r_pc  [IQ_DEPTH];
  logic [XLEN-1:0] r_ppc [IQ_DEPTH];
  logic            r_pj  [IQ_DEPTH];
  logic [AW-1:0]   r_head, r_tail;
  logic [AW:0]     r_cnt;
  logic            w_full, w_empty, w_fire, w_push, w_pop;
  logic [XLEN+ROB_W-1:0] w_j, w_k;

  // Lowest-index CDB channel wins when several broadcast the same tag.
  function automatic logic [XLEN+ROB_W-1:0] resolve(
    input logic [ROB_W-1:0] q,
    input logic [XLEN-1:0]  rv,
    input logic             rr,
    input logic [XLEN-1:0]  robv
  );
    logic            hit;
    logic [XLEN-1:0] v;
    hit = 1'b0;
    v   = '0;
    for (int i = CDB_CH - 1; i >= 0; i--) begin
      if (cdb_valid[i] && cdb_rob_id[i*ROB_W +: ROB_W] == q) begin
        hit = 1'b1;
        v   = cdb_value[i*XLEN +: XLEN];
      end
    end
    if (q == '0)   return {rv, {ROB_W{1'b0}}};
    else if (hit)  return {v, {ROB_W{1'b0}}};
    else if (rr)   return {robv, {ROB_W{1'b0}}};
    else           return {{XLEN{1'b0}}, q};
  endfunction

  assign w_full   = r_cnt == (AW+1)'(IQ_DEPTH);
  assign w_empty  = r_cnt == '0;
  assign if_ready = !w_full;
  assign w_fire   = !w_empty && rob_ready && (dec_is_mem ? lsb_ready : rs_ready);
  assign w_push   = rdy && !flush && if_valid && !w_full;
  assign w_pop    = rdy && !flush && w_fire;

  assign dec_code = r_ins[r_head];
  assign dec_pc   = r_pc[r_head];
  assign reg_rs1  = dec_rs1;
  assign reg_rs2  = dec_rs2;
  assign rob_Qj   = reg_Qj;
  assign rob_Qk   = reg_Qk;
  assign w_j      = resolve(reg_Qj, reg_Vj, rob_Qj_ready, rob_Vj);
  assign w_k      = resolve(reg_Qk, reg_Vk, rob_Qk_ready, rob_Vk);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ins[r_tail] <= if_ins;
      r_pc[r_tail]  <= if_pc;
      r_ppc[r_tail] <= if_pred_pc;
      r_pj[r_tail]  <= if_pred_jump;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else if (rdy) begin
      if (flush) begin
        r_head <= '0;
        r_tail <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + AW'(1);
        if (w_pop)  r_head <= r_head + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
          2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rob_en        <= 1'b0;
      rs_en         <= 1'b0;
      lsb_en        <= 1'b0;
      rename_en     <= 1'b0;
      rename_rd     <= '0;
      rename_id     <= '0;
      out_Vj        <= '0;
      out_Vk        <= '0;
      out_Qj        <= '0;
      out_Qk        <= '0;
      out_type      <= '0;
      out_rd        <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_imm       <= '0;
      out_pc        <= '0;
      out_pred_pc   <= '0;
      out_pred_jump <= 1'b0;
    end else if (rdy) begin
      rob_en    <= w_pop;
      rename_en <= w_pop;
      rs_en     <= w_pop && !dec_is_mem;
      lsb_en    <= w_pop && dec_is_mem;
      if (w_pop) begin
        rename_rd     <= dec_rd;
        rename_id     <= rob_free_id;
        out_Vj        <= w_j[ROB_W +: XLEN];
        out_Qj        <= w_j[ROB_W-1:0];
        out_Vk        <= w_k[ROB_W +: XLEN];
        out_Qk        <= w_k[ROB_W-1:0];
        out_type      <= dec_type;
        out_rd        <= dec_rd;
        out_rs1       <= dec_rs1;
        out_rs2       <= dec_rs2;
        out_imm       <= dec_imm;
        out_pc        <= r_pc[r_head];
        out_pred_pc   <= r_ppc[r_head];
        out_pred_jump <= r_pj[r_head];
      end
    end
  end
endmodule
